uwb_packet_reader: RTL and testbench
====================================

# uwb_packet_reader

Receive-side counterpart of the UWB packet writer. It consumes the byte stream read out of the receiving UWB radio's RX buffer and parses each 64-byte payload: a 4-byte mirror phase stamp followed by 60 ADC samples. It emits one sample per handshake, tagged with a reconstructed X/Y mirror phase, for the image-assembly logic downstream.

## Interface
Parameters:
- `N_STAMP`, 4: stamp bytes per packet, in the order timerX[15:8], timerX[7:0], timerY[15:8], timerY[7:0].
- `N_DATA`, 60: sample bytes per packet.
- `PHASE_STEP`, 2: transmitter clock cycles between consecutive samples.

Ports:
- `clk`, in, 1: single clock; the design uses one clock only.
- `rst`, in, 1: synchronous, active-high reset.
- `in_data`, in, 8: payload byte from the RX SPI path.
- `in_valid`, in, 1: `in_data` is valid this cycle.
- `in_sop`, in, 1: qualifies `in_data` as the first payload byte of a packet.
- `in_ready`, out, 1: the block accepts the byte this cycle.
- `period_x`, in, 16: mirror X period configuration; must match the transmitter's `periodX`.
- `period_y`, in, 16: mirror Y period configuration; must match the transmitter's `periodY`.
- `pix_data`, out, 8: sample value.
- `pix_phase_x`, out, 16: reconstructed X phase of the sample.
- `pix_phase_y`, out, 16: reconstructed Y phase of the sample.
- `pix_last`, out, 1: this is sample 59 of its packet.
- `pix_valid`, out, 1: output word valid.
- `pix_ready`, in, 1: downstream accepts the output word.
- `pkt_count`, out, 16: number of complete packets; wraps.
- `err_count`, out, 8: number of truncated packets; saturates at 255.
- `busy`, out, 1: parser is not in IDLE.

## Operation
- A byte is accepted on a rising edge when `in_valid && in_ready` is true.
- State machine with states IDLE, STAMP, DATA:
  - **IDLE:** `in_ready`=1. An accepted byte with `in_sop`=1 loads the timerX high byte, sets byte index=1 and moves to STAMP. An accepted byte with `in_sop`=0 is dropped silently; this covers radio padding.
  - **STAMP:** `in_ready`=1. Bytes 1..3 fill the stamp. On byte 3, load `phase_x` and `phase_y` from the stamp, clear the sample index, and move to DATA.
  - **DATA:** `in_ready` = `~pix_valid | pix_ready`. Each accepted byte loads the output register:
    - `pix_data` = the byte.
    - `pix_phase_x` and `pix_phase_y` = the current phases.
    - `pix_last` = (sample index == 59).
  - After loading, the phases advance and the index increments. On sample 59, `pkt_count` increments and the state returns to IDLE.
- **Phase advance**, applied per axis using 17-bit arithmetic: s = phase + PHASE_STEP. If s > period, next = s − (period + 1); otherwise next = s. The result matches the transmitter timer, which counts 0..period.
- **Stamp out of range:** a stamp value greater than its period loads as 0 for that axis.
- **Period of 0:** the phase for that axis is held at 0.
- **Truncation:** an accepted byte with `in_sop`=1 while in STAMP or DATA aborts the current packet.
  - `err_count` increments.
  - Output words already issued stand.
  - The byte is treated as stamp byte 0 of a new packet.
- **Period changes:** `period_x` and `period_y` are sampled on every phase advance. Changing them mid-packet affects only subsequent advances.

## Timing
- **Reset values:**
  - State = IDLE.
  - `pix_valid`=0, `pix_data`=0, `pix_phase_x`=0, `pix_phase_y`=0, `pix_last`=0.
  - `pkt_count`=0, `err_count`=0, `busy`=0.
  - `in_ready`=1.
- **Reset mid-packet:** the partial packet is discarded with no error count, and any pending output word is dropped.
- **Latency:** a sample accepted at edge N gives `pix_valid`=1 with that word during the cycle after edge N. Stamp bytes produce no output.
- **Output handshake:**
  - A word transfers at an edge with `pix_valid && pix_ready`.
  - `pix_valid` clears at that edge unless a new sample is accepted at the same edge; in that case the register reloads and `pix_valid` stays 1.
  - While `pix_valid`=1 and `pix_ready`=0, all outputs hold stable.
- **Throughput:** sustained one sample per cycle when `pix_ready`=1. A packet takes 64 accepted bytes, with no dead cycle between packets.
- **Counters:** `pkt_count` updates at the edge that accepts sample 59. `err_count` updates at the edge that accepts the aborting `in_sop` byte.
- **busy:** registered; equals (state != IDLE) and is valid the cycle after the transition.

## Test plan
- **Clean packet:** `period_x`=0x0100, `period_y`=0x0101, stamp 0x0010/0x0020, data 0..59, `pix_ready`=1.
  - Expect 60 words with `pix_data`=k, `pix_phase_x`=0x10+2k, `pix_phase_y`=0x20+2k.
  - Expect `pix_last` only on k=59 and `pkt_count`=1.
- **Wrap:** `period_x`=0x0100, stamp X=0x00FF.
  - Sample phases 0x00FF, 0x0000, 0x0002.
  - Stamp 0x0100 gives 0x0100, 0x0001.
- **Backpressure:** hold `pix_ready`=0 after sample 3.
  - `in_ready`=0, and sample 3 holds stable for 10 cycles.
  - On release, no sample is lost or duplicated and phases continue by +2.
- **Truncation:** assert `in_sop` at sample 20, then send a full packet.
  - Expect `err_count`=1 and `pkt_count`=1.
  - The second packet's phases derive from its own stamp.
  - Idle padding bytes without `in_sop` produce no output.
- **Reset mid-DATA** at sample 30 with `pix_valid`=1.
  - Next cycle: `pix_valid`=0, `busy`=0, counters=0.
  - A following packet parses cleanly.
- **Out-of-range stamp:** X stamp 0x0300 with `period_x`=0x0100 gives phases 0, 2, 4.
  - `period_y`=0 gives all Y phases 0.

Source files
------------

// File: rtl/uwb_packet_reader.sv
// uwb_packet_reader: parses 64-byte UWB payloads (4-byte mirror phase stamp
// followed by 60 ADC samples) into phase-tagged sample words.
module uwb_packet_reader #(
   parameter int N_STAMP    = 4,
   parameter int N_DATA     = 60,
   parameter int PHASE_STEP = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_sop,
   output logic        in_ready,
   input  logic [15:0] period_x,
   input  logic [15:0] period_y,
   output logic [7:0]  pix_data,
   output logic [15:0] pix_phase_x,
   output logic [15:0] pix_phase_y,
   output logic        pix_last,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [15:0] pkt_count,
   output logic [7:0]  err_count,
   output logic        busy
);

   localparam int SIW = $clog2(N_DATA);
   localparam int BIW = $clog2(N_STAMP);

   typedef enum logic [1:0] {IDLE, STAMP, DATA} state_t;

   state_t           state, state_nxt;
   logic [BIW-1:0]   byte_idx;
   logic [SIW-1:0]   sample_idx;
   logic [7:0]       stamp_xh, stamp_xl, stamp_yh;
   logic [15:0]      phase_x, phase_y;
   logic             accept, take_sample, stamp_done, last_sample;

   // Step a phase by PHASE_STEP, wrapping the way the transmitter timer counts
   // 0..period; a period of 0 pins the axis at 0.
   function automatic logic [15:0] advance(input logic [15:0] phase, input logic [15:0] period);
      logic [16:0] s;
      logic [16:0] lim;
      s   = {1'b0, phase} + 17'(PHASE_STEP);
      lim = {1'b0, period};
      if (period == '0)
         advance = '0;
      else if (s > lim)
         advance = 16'(s - lim - 17'd1);
      else
         advance = s[15:0];
   endfunction

   // A stamp beyond its period cannot be a real timer value; start that axis at 0.
   function automatic logic [15:0] load_stamp(input logic [15:0] stamp, input logic [15:0] period);
      load_stamp = (stamp > period) ? 16'd0 : stamp;
   endfunction

   // Handshake decode: in DATA the output register must be free (or freeing) to take a byte.
   // NOTE: in_ready is combinational on pix_ready so a full-rate stream needs no skid buffer.
   always_comb begin
      in_ready    = (state == DATA) ? (~pix_valid | pix_ready) : 1'b1;
      accept      = in_valid & in_ready;
      last_sample = (sample_idx == SIW'(N_DATA - 1));
      take_sample = accept & ~in_sop & (state == DATA);
      stamp_done  = accept & ~in_sop & (state == STAMP) & (byte_idx == BIW'(N_STAMP - 1));
   end

   // Next-state logic; an in_sop byte always restarts stamp collection.
   // NOTE: state_nxt gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && in_sop) state_nxt = STAMP;
         STAMP:   if (accept) begin
                     if (in_sop)          state_nxt = STAMP;
                     else if (stamp_done) state_nxt = DATA;
                  end
         DATA:    if (accept) begin
                     if (in_sop)           state_nxt = STAMP;
                     else if (last_sample) state_nxt = IDLE;
                  end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Stamp byte capture; stamp bytes themselves need no reset since they are
   // always written before they are consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx <= '0;
      end else if (accept && in_sop) begin
         stamp_xh <= in_data;
         byte_idx <= BIW'(1);
      end else if (accept && state == STAMP) begin
         case (byte_idx)
            BIW'(1): stamp_xl <= in_data;
            BIW'(2): stamp_yh <= in_data;
            default: ;
         endcase
         byte_idx <= byte_idx + BIW'(1);
      end
   end

   // Phase tracking and sample index: loaded from the stamp, advanced per sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_x    <= '0;
         phase_y    <= '0;
         sample_idx <= '0;
      end else if (stamp_done) begin
         phase_x    <= load_stamp({stamp_xh, stamp_xl}, period_x);
         phase_y    <= load_stamp({stamp_yh, in_data}, period_y);
         sample_idx <= '0;
      end else if (take_sample) begin
         phase_x    <= advance(phase_x, period_x);
         phase_y    <= advance(phase_y, period_y);
         sample_idx <= sample_idx + SIW'(1);
      end
   end

   // Output word register: reloads on each sample, empties when taken downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_valid   <= 1'b0;
         pix_data    <= '0;
         pix_phase_x <= '0;
         pix_phase_y <= '0;
         pix_last    <= 1'b0;
      end else if (take_sample) begin
         pix_valid   <= 1'b1;
         pix_data    <= in_data;
         pix_phase_x <= phase_x;
         pix_phase_y <= phase_y;
         pix_last    <= last_sample;
      end else if (pix_ready) begin
         pix_valid   <= 1'b0;
      end
   end

   // Packet / truncation counters and the registered busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_count <= '0;
         err_count <= '0;
         busy      <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         if (take_sample && last_sample)
            pkt_count <= pkt_count + 16'd1;
         if (accept && in_sop && state != IDLE && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_uwb_packet_reader.sv
// Self-checking bench for uwb_packet_reader: scoreboard of expected words
// filled as samples are driven, drained by a monitor on the falling edge.
module tb_uwb_packet_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid, in_sop, in_ready;
   logic [15:0] period_x, period_y;
   logic [7:0]  pix_data;
   logic [15:0] pix_phase_x, pix_phase_y;
   logic        pix_last, pix_valid, pix_ready;
   logic [15:0] pkt_count;
   logic [7:0]  err_count;
   logic        busy;

   typedef struct packed {
      logic [7:0]  data;
      logic [15:0] px;
      logic [15:0] py;
      logic        last;
   } word_t;

   word_t       exp_q[$];
   word_t       got, exp_w;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [15:0] m_px, m_py;
   int          m_k;

   uwb_packet_reader dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
      .in_ready(in_ready), .period_x(period_x), .period_y(period_y),
      .pix_data(pix_data), .pix_phase_x(pix_phase_x), .pix_phase_y(pix_phase_y),
      .pix_last(pix_last), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pkt_count(pkt_count), .err_count(err_count), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference phase model written from the timer behaviour: counts 0..period.
   function automatic logic [15:0] m_adv(input logic [15:0] p, input logic [15:0] per);
      int s;
      if (per == 0) return 16'd0;
      s = int'(p) + 2;
      if (s > int'(per)) return 16'(s - int'(per) - 1);
      return 16'(s);
   endfunction

   function automatic logic [15:0] m_load(input logic [15:0] st, input logic [15:0] per);
      return (st > per) ? 16'd0 : st;
   endfunction

   // Monitor: every transferred word must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst === 1'b0 && pix_valid === 1'b1 && pix_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(pix_data), 64'hDEAD);
         end else begin
            exp_w = exp_q.pop_front();
            got   = '{pix_data, pix_phase_x, pix_phase_y, pix_last};
            check("word", 64'(got), 64'(exp_w));
         end
      end
   end

   // Drive one byte and hold it until accepted (bounded); returns #1 after the accepting edge.
   task automatic send_byte(input logic [7:0] d, input logic sop);
      int n = 0;
      in_data = d; in_sop = sop; in_valid = 1'b1;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_sop = 1'b0;
   endtask

   task automatic start_packet(input logic [15:0] sx, input logic [15:0] sy);
      send_byte(sx[15:8], 1'b1);
      send_byte(sx[7:0], 1'b0);
      send_byte(sy[15:8], 1'b0);
      send_byte(sy[7:0], 1'b0);
      m_px = m_load(sx, period_x);
      m_py = m_load(sy, period_y);
      m_k  = 0;
   endtask

   task automatic send_sample(input logic [7:0] d);
      exp_q.push_back('{d, m_px, m_py, (m_k == 59)});
      m_px = m_adv(m_px, period_x);
      m_py = m_adv(m_py, period_y);
      m_k++;
      send_byte(d, 1'b0);
   endtask

   task automatic send_samples(input int from, input int to);
      for (int k = from; k <= to; k++) send_sample(8'(k));
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || pix_valid === 1'b1) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      rst = 1'b0;
   endtask

   initial begin
      int t0;
      rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; pix_ready = 1'b1;
      period_x = 16'h0100; period_y = 16'h0101;
      repeat (3) @(posedge clk);
      #1;
      // Reset values
      check("rst_pix_valid", 64'(pix_valid), 64'd0);
      check("rst_pix_data", 64'(pix_data), 64'd0);
      check("rst_phases", 64'({pix_phase_x, pix_phase_y}), 64'd0);
      check("rst_pix_last", 64'(pix_last), 64'd0);
      check("rst_counters", 64'({pkt_count, err_count}), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Clean packet, full rate: 64 accepted bytes in 64 cycles
      t0 = cyc;
      send_byte(8'h00, 1'b1);
      check("busy_after_sop", 64'(busy), 64'd1);
      send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h20, 1'b0);
      m_px = 16'h0010; m_py = 16'h0020; m_k = 0;
      send_samples(0, 59);
      check("clean_cycles", 64'(cyc - t0), 64'd64);
      check("clean_last", 64'(pix_last), 64'd1);
      check("clean_pkt_count", 64'(pkt_count), 64'd1);
      check("clean_busy_end", 64'(busy), 64'd0);
      drain("clean_drain");

      // Wrap of X phase at period
      start_packet(16'h00FF, 16'h0000);
      send_sample(8'd0); check("wrap_s0", 64'(pix_phase_x), 64'h00FF);
      send_sample(8'd1); check("wrap_s1", 64'(pix_phase_x), 64'h0000);
      send_sample(8'd2); check("wrap_s2", 64'(pix_phase_x), 64'h0002);
      send_samples(3, 59);
      start_packet(16'h0100, 16'h0010);
      send_sample(8'd0); check("wrapmax_s0", 64'(pix_phase_x), 64'h0100);
      send_sample(8'd1); check("wrapmax_s1", 64'(pix_phase_x), 64'h0001);
      send_samples(2, 59);
      drain("wrap_drain");
      check("wrap_pkt_count", 64'(pkt_count), 64'd3);

      // Backpressure: stall with sample 3 in the output register
      start_packet(16'h0030, 16'h0040);
      send_samples(0, 3);
      pix_ready = 1'b0;
      in_data = 8'd4; in_sop = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_hold", 64'({pix_valid, pix_data, pix_phase_x, pix_phase_y, pix_last}),
               64'({1'b1, 8'd3, 16'h0036, 16'h0046, 1'b0}));
      end
      @(posedge clk);
      #1;
      pix_ready = 1'b1;
      send_samples(4, 59);
      drain("bp_drain");

      // Truncation then a full packet, then padding
      do_reset();
      start_packet(16'h0040, 16'h0050);
      send_samples(0, 19);
      send_byte(8'h00, 1'b1);
      check("trunc_err_count", 64'(err_count), 64'd1);
      send_byte(8'h05, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h07, 1'b0);
      m_px = 16'h0005; m_py = 16'h0007; m_k = 0;
      send_sample(8'd0); check("trunc_new_phase", 64'({pix_phase_x, pix_phase_y}), 64'h0005_0007);
      send_samples(1, 59);
      drain("trunc_drain");
      check("trunc_counts", 64'({pkt_count, err_count}), 64'h0001_01);
      for (int i = 0; i < 5; i++) send_byte(8'hA5, 1'b0);
      @(negedge clk);
      check("pad_no_output", 64'({pix_valid, busy}), 64'd0);
      check("pad_queue", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of DATA with a word pending
      start_packet(16'h0011, 16'h0022);
      send_samples(0, 29);
      check("midrst_pending", 64'(pix_valid), 64'd1);
      do_reset();
      check("midrst_pix_valid", 64'(pix_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_counters", 64'({pkt_count, err_count}), 64'd0);
      start_packet(16'h0011, 16'h0022);
      send_samples(0, 59);
      drain("midrst_drain");
      check("midrst_after_counts", 64'({pkt_count, err_count}), 64'h0001_00);

      // Out-of-range X stamp and period_y of 0
      period_y = 16'h0000;
      start_packet(16'h0300, 16'h0055);
      send_sample(8'd0); check("oor_s0", 64'({pix_phase_x, pix_phase_y}), 64'h0000_0000);
      send_sample(8'd1); check("oor_s1", 64'({pix_phase_x, pix_phase_y}), 64'h0002_0000);
      send_sample(8'd2); check("oor_s2", 64'({pix_phase_x, pix_phase_y}), 64'h0004_0000);
      send_samples(3, 59);
      drain("oor_drain");
      check("oor_pkt_count", 64'(pkt_count), 64'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
